// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS trace buffer: capture states, capture modes and the trace-entry layout.
package mips_pkg;

  typedef enum logic [1:0] {
    TRC_IDLE  = 2'd0,
    TRC_ARMED = 2'd1,
    TRC_POST  = 2'd2,
    TRC_DONE  = 2'd3
  } trc_state_e;

  typedef enum logic [1:0] {
    TRC_WRAP = 2'd0,
    TRC_FILL = 2'd1,
    TRC_TRIG = 2'd2
  } trc_mode_e;

  // One retired instruction at the default 32-bit datapath width.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] result;
  } trc_entry_t;

  // Reserved mode encoding 3 behaves as WRAP.
  function automatic trc_mode_e trc_mode_decode(input logic [1:0] mode);
    case (mode)
      2'd1:    return TRC_FILL;
      2'd2:    return TRC_TRIG;
      default: return TRC_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/mips_trace_buffer_trace_ram.sv
// Simple dual-port RAM: one write port, one registered read port (old data on same-address collision).
module trace_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mips_trace_buffer.sv
// Instruction trace buffer: snoops retired {PC, INS, RESULT} into a circular RAM with WRAP/FILL/TRIG capture.
// Optional macro MIPS_TRACE_RESULT_EN stores the RESULT column; otherwise RD_RESULT reads 0.
//
// state     | meaning
// ----------+---------------------------------------------------------
// TRC_IDLE  | after reset, nothing captured
// TRC_ARMED | capturing; FILL ends when full, TRIG watches for TRIG_PC
// TRC_POST  | trigger seen, capturing the remaining post-trigger entries
// TRC_DONE  | buffer frozen until the next ARM
module mips_trace_buffer
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CAP_VALID,
  input  logic [DATA_W-1:0] CAP_PC,
  input  logic [31:0]       CAP_INS,
  input  logic [DATA_W-1:0] CAP_RESULT,
  input  logic [1:0]        MODE,
  input  logic              ARM,
  input  logic              STOP,
  input  logic [DATA_W-1:0] TRIG_PC,
  input  logic [IDX_W-1:0]  POST_CNT,
  input  logic              RD_EN,
  input  logic [IDX_W-1:0]  RD_IDX,
  output logic              RD_VALID,
  output logic [DATA_W-1:0] RD_PC,
  output logic [31:0]       RD_INS,
  output logic [DATA_W-1:0] RD_RESULT,
  output logic [IDX_W:0]    COUNT,
  output logic [1:0]        STATE,
  output logic              TRIGGERED
);

`ifdef MIPS_TRACE_RESULT_EN
  localparam int ENTRY_W = 2*DATA_W + 32;
`else
  localparam int ENTRY_W = DATA_W + 32;
`endif
  localparam logic [IDX_W:0] CNT_FULL = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W+1)'(DEPTH-1);

  trc_state_e        state_q, state_d;
  trc_mode_e         mode_q, mode_d;
  logic [IDX_W-1:0]  wptr_q, wptr_d;
  logic [IDX_W:0]    count_q, count_d;
  logic              trig_q, trig_d;
  logic [DATA_W-1:0] trig_pc_q, trig_pc_d;
  logic [IDX_W-1:0]  post_cnt_q, post_cnt_d;
  logic [IDX_W-1:0]  post_q, post_d;

  logic               wr_en;
  logic [ENTRY_W-1:0] wr_data;
  logic [IDX_W-1:0]   rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  logic               rd_valid_q;
  logic               rd_ok_q;

  // ARM takes priority, so the capture presented in the ARM cycle is dropped.
  assign wr_en = CAP_VALID && !ARM && (state_q == TRC_ARMED || state_q == TRC_POST);

`ifdef MIPS_TRACE_RESULT_EN
  assign wr_data = {CAP_PC, CAP_INS, CAP_RESULT};
`else
  logic unused_cap_result;
  assign unused_cap_result = ^CAP_RESULT;
  assign wr_data = {CAP_PC, CAP_INS};
`endif

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    trig_d     = trig_q;
    trig_pc_d  = trig_pc_q;
    post_cnt_d = post_cnt_q;
    post_d     = post_q;
    if (ARM) begin
      state_d    = TRC_ARMED;
      mode_d     = trc_mode_decode(MODE);
      wptr_d     = '0;
      count_d    = '0;
      trig_d     = 1'b0;
      trig_pc_d  = TRIG_PC;
      post_cnt_d = POST_CNT;
    end else begin
      if (wr_en) begin
        wptr_d = wptr_q + IDX_W'(1);
        if (count_q != CNT_FULL) count_d = count_q + (IDX_W+1)'(1);
      end
      case (state_q)
        TRC_ARMED: begin
          if (wr_en && mode_q == TRC_FILL && count_q == CNT_LAST) state_d = TRC_DONE;
          if (wr_en && mode_q == TRC_TRIG && CAP_PC == trig_pc_q) begin
            trig_d = 1'b1;
            if (post_cnt_q == '0) begin
              state_d = TRC_DONE;
            end else begin
              state_d = TRC_POST;
              post_d  = post_cnt_q;
            end
          end
          if (STOP) state_d = TRC_DONE;
        end
        TRC_POST: begin
          if (wr_en) begin
            post_d = post_q - IDX_W'(1);
            if (post_q == IDX_W'(1)) state_d = TRC_DONE;
          end
          if (STOP) state_d = TRC_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= TRC_IDLE;
      mode_q     <= TRC_WRAP;
      wptr_q     <= '0;
      count_q    <= '0;
      trig_q     <= 1'b0;
      trig_pc_q  <= '0;
      post_cnt_q <= '0;
      post_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      trig_q     <= trig_d;
      trig_pc_q  <= trig_pc_d;
      post_cnt_q <= post_cnt_d;
      post_q     <= post_d;
    end
  end

  // Oldest entry sits COUNT slots behind the write pointer; wraps naturally in IDX_W bits.
  assign rd_addr = wptr_q - count_q[IDX_W-1:0] + RD_IDX;

  trace_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (CLK),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata (wr_data),
    .re    (RD_EN),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // rd_ok_q masks the unreset RAM output register and out-of-range indices.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_valid_q <= 1'b0;
      rd_ok_q    <= 1'b0;
    end else begin
      rd_valid_q <= RD_EN;
      if (RD_EN) rd_ok_q <= ({1'b0, RD_IDX} < count_q);
    end
  end

  assign RD_VALID = rd_valid_q;
  assign RD_PC    = rd_ok_q ? rd_data[ENTRY_W-1 -: DATA_W] : '0;
  assign RD_INS   = rd_ok_q ? rd_data[ENTRY_W-DATA_W-1 -: 32] : '0;
`ifdef MIPS_TRACE_RESULT_EN
  assign RD_RESULT = rd_ok_q ? rd_data[DATA_W-1:0] : '0;
`else
  assign RD_RESULT = '0;
`endif

  assign COUNT     = count_q;
  assign STATE     = state_q;
  assign TRIGGERED = trig_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer: table-driven capture modes, read scoreboard, corner sequences.
module tb_mips_trace_buffer;
  import mips_pkg::*;

  logic        CLK, RST_N;
  logic        CAP_VALID, ARM, STOP, RD_EN;
  logic [31:0] CAP_PC, CAP_INS, CAP_RESULT, TRIG_PC;
  logic [1:0]  MODE;
  logic [3:0]  POST_CNT, RD_IDX;
  logic        RD_VALID, TRIGGERED;
  logic [31:0] RD_PC, RD_INS, RD_RESULT;
  logic [4:0]  COUNT;
  logic [1:0]  STATE;

  int checks = 0;
  int errors = 0;
  trc_entry_t exp_q[$];
  logic chk_req;

  mips_trace_buffer dut (
    .CLK(CLK), .RST_N(RST_N), .CAP_VALID(CAP_VALID), .CAP_PC(CAP_PC), .CAP_INS(CAP_INS),
    .CAP_RESULT(CAP_RESULT), .MODE(MODE), .ARM(ARM), .STOP(STOP), .TRIG_PC(TRIG_PC),
    .POST_CNT(POST_CNT), .RD_EN(RD_EN), .RD_IDX(RD_IDX), .RD_VALID(RD_VALID), .RD_PC(RD_PC),
    .RD_INS(RD_INS), .RD_RESULT(RD_RESULT), .COUNT(COUNT), .STATE(STATE), .TRIGGERED(TRIGGERED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f_ins(input logic [31:0] pc);
    return 32'h2400_0000 | pc;
  endfunction

  function automatic logic [31:0] exp_res(input logic [31:0] r);
`ifdef MIPS_TRACE_RESULT_EN
    return r;
`else
    return 32'h0;
`endif
  endfunction

  function automatic trc_entry_t ent(input logic [31:0] pc);
    trc_entry_t e;
    e.pc = pc; e.ins = f_ins(pc); e.result = exp_res(pc + 32'h1000);
    return e;
  endfunction

  // Read scoreboard: a request seen at an edge must yield valid data after the next edge.
  always @(posedge CLK) begin
    chk_req = RD_EN;
    #1;
    if (chk_req) begin
      trc_entry_t e;
      chk("rd_valid", 64'(RD_VALID), 64'd1);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_queue: read returned with no expected entry queued");
      end else begin
        e = exp_q.pop_front();
        chk("rd_pc", 64'(RD_PC), 64'(e.pc));
        chk("rd_ins", 64'(RD_INS), 64'(e.ins));
        chk("rd_result", 64'(RD_RESULT), 64'(e.result));
      end
    end else if (RD_VALID !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_idle: got %0b expected 0", RD_VALID);
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic arm(input logic [1:0] m, input logic [31:0] tpc, input logic [3:0] pc_n);
    MODE = m; TRIG_PC = tpc; POST_CNT = pc_n; ARM = 1'b1;
    tick();
    ARM = 1'b0;
  endtask

  task automatic cap(input logic [31:0] pc, input logic [31:0] res);
    CAP_VALID = 1'b1; CAP_PC = pc; CAP_INS = f_ins(pc); CAP_RESULT = res;
    tick();
    CAP_VALID = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input trc_entry_t e);
    RD_EN = 1'b1; RD_IDX = idx; exp_q.push_back(e);
    tick();
    RD_EN = 1'b0;
  endtask

  task automatic stop();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] trig_pc;
    logic [3:0]  post_cnt;
    int          n_caps;
    bit          do_stop;
    logic [4:0]  exp_count;
    logic        exp_trig;
    logic [3:0]  last_idx;
    logic [31:0] exp_pc0;
    logic [31:0] exp_pc_last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    trc_entry_t z;
    z = '0;
    vecs[0] = '{2'd1, 32'h8,  4'd0, 20, 1'b0, 5'd16, 1'b0, 4'd15, 32'h0,  32'h3C};
    vecs[1] = '{2'd0, 32'h8,  4'd0, 20, 1'b1, 5'd16, 1'b0, 4'd15, 32'h10, 32'h4C};
    vecs[2] = '{2'd2, 32'h20, 4'd3, 20, 1'b0, 5'd12, 1'b1, 4'd11, 32'h0,  32'h2C};
    vecs[3] = '{2'd2, 32'h20, 4'd0, 20, 1'b0, 5'd9,  1'b1, 4'd8,  32'h0,  32'h20};
    vecs[4] = '{2'd3, 32'h8,  4'd0, 5,  1'b1, 5'd5,  1'b0, 4'd4,  32'h0,  32'h10};

    RST_N = 1'b0; CAP_VALID = 0; ARM = 0; STOP = 0; RD_EN = 0;
    CAP_PC = 0; CAP_INS = 0; CAP_RESULT = 0; TRIG_PC = 0; MODE = 0; POST_CNT = 0; RD_IDX = 0;
    tick(); tick();
    chk("reset_state", 64'(STATE), 64'd0);
    chk("reset_count", 64'(COUNT), 64'd0);
    chk("reset_trig", 64'(TRIGGERED), 64'd0);
    chk("reset_rd_pc", 64'(RD_PC), 64'd0);
    chk("reset_rd_result", 64'(RD_RESULT), 64'd0);
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) cap(32'h40 + 32'(i*4), 32'h0);
    chk("idle_count", 64'(COUNT), 64'd0);
    chk("idle_state", 64'(STATE), 64'd0);

    for (int v = 0; v < 5; v++) begin
      arm(vecs[v].mode, vecs[v].trig_pc, vecs[v].post_cnt);
      chk("arm_state", 64'(STATE), 64'd1);
      chk("arm_count", 64'(COUNT), 64'd0);
      for (int i = 0; i < vecs[v].n_caps; i++) begin
        logic [31:0] pc;
        pc = 32'(i*4);
        cap(pc, pc + 32'h1000);
        if (vecs[v].mode == 2'd1 && i == 15) chk("fill_done_16th", 64'(STATE), 64'd3);
        if (vecs[v].mode == 2'd2 && pc == vecs[v].trig_pc) chk("trig_hit", 64'(TRIGGERED), 64'd1);
        if (vecs[v].mode == 2'd2 && pc == vecs[v].trig_pc - 32'h4) chk("trig_before", 64'(TRIGGERED), 64'd0);
      end
      if (vecs[v].do_stop) stop();
      chk("vec_state", 64'(STATE), 64'd3);
      chk("vec_count", 64'(COUNT), 64'(vecs[v].exp_count));
      chk("vec_trig", 64'(TRIGGERED), 64'(vecs[v].exp_trig));
      rd(4'd0, ent(vecs[v].exp_pc0));
      rd(vecs[v].last_idx, ent(vecs[v].exp_pc_last));
      tick();
    end

    // ARM and STOP together with a capture in the same cycle
    ARM = 1'b1; STOP = 1'b1; MODE = 2'd0; CAP_VALID = 1'b1; CAP_PC = 32'hF0; CAP_INS = f_ins(32'hF0);
    tick();
    ARM = 1'b0; STOP = 1'b0; CAP_VALID = 1'b0;
    chk("arm_stop_state", 64'(STATE), 64'd1);
    chk("arm_cap_count", 64'(COUNT), 64'd0);
    for (int i = 0; i < 3; i++) cap(32'h100 + 32'(i*4), 32'h1100 + 32'(i*4));
    chk("three_count", 64'(COUNT), 64'd3);
    rd(4'd5, z);
    rd(4'd0, ent(32'h100));
    rd(4'd1, ent(32'h104));
    rd(4'd2, ent(32'h108));
    tick();

    // ARM mid-capture discards prior contents
    arm(2'd0, 32'h0, 4'd0);
    chk("rearm_count", 64'(COUNT), 64'd0);
    cap(32'h300, 32'h1300);
    rd(4'd0, ent(32'h300));
    rd(4'd1, z);

    // Read-during-write on the same physical entry returns old data
    arm(2'd0, 32'h0, 4'd0);
    for (int i = 0; i < 16; i++) cap(32'h400 + 32'(i*4), 32'h1400 + 32'(i*4));
    CAP_VALID = 1'b1; CAP_PC = 32'h440; CAP_INS = f_ins(32'h440); CAP_RESULT = 32'h1440;
    RD_EN = 1'b1; RD_IDX = 4'd0; exp_q.push_back(ent(32'h400));
    tick();
    CAP_VALID = 1'b0; RD_EN = 1'b0;
    rd(4'd0, ent(32'h404));
    rd(4'd15, ent(32'h440));
    stop();
    chk("wrap_stop_state", 64'(STATE), 64'd3);

    // RESULT column with a distinctive value
    arm(2'd0, 32'h0, 4'd0);
    cap(32'h200, 32'hDEADBEEF);
    rd(4'd0, '{pc: 32'h200, ins: f_ins(32'h200), result: exp_res(32'hDEADBEEF)});
    stop();

    // Asynchronous reset in POST with a read just returned
    arm(2'd2, 32'h0, 4'd5);
    cap(32'h0, 32'h1000);
    chk("post_state", 64'(STATE), 64'd2);
    rd(4'd0, ent(32'h0));
    #2 RST_N = 1'b0;
    #1;
    chk("arst_state", 64'(STATE), 64'd0);
    chk("arst_count", 64'(COUNT), 64'd0);
    chk("arst_trig", 64'(TRIGGERED), 64'd0);
    chk("arst_rd_valid", 64'(RD_VALID), 64'd0);
    chk("arst_rd_pc", 64'(RD_PC), 64'd0);
    tick();
    RST_N = 1'b1;
    tick(); tick();
    chk("rd_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
